// File: rtl/fetch_unit_pkg.sv
// Shared constants, the IF/ID bundle and the fetch-address legality check.
// Imported by the fetch stage and its pipeline register.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int unsigned MEM_BYTES = 1000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic legal_addr(
    input logic [31:0] a,
    input logic [31:0] bytes
  );
    return (a[1:0] == ALIGN_MASK) && (a <= bytes - 32'd4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush.
// Flush and reset both leave a NOP bubble with valid cleared.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        valid
);

  if_id_t q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= '{instr: NOP, pc: 32'd0,
             pc4: 32'd0, valid: 1'b0};
    end else if (load) begin
      q <= '{instr: instr_d, pc: pc_d,
             pc4: pc4_d, valid: 1'b1};
    end
  end

  assign instr = q.instr;
  assign pc    = q.pc;
  assign pc4   = q.pc4;
  assign valid = q.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC selection, address-fault
// check, delivered-instruction counter and the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = fetch_unit_pkg::RESET_PC,
  parameter int unsigned MEM_BYTES = fetch_unit_pkg::MEM_BYTES,
  parameter logic [31:0] NOP_WORD  = fetch_unit_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic [31:0] ins_i,
  output logic [31:0] dr_o,
  output logic [31:0] instr_id_o,
  output logic [31:0] pc_id_o,
  output logic [31:0] pc4_id_o,
  output logic        valid_id_o,
  output logic        fault_o,
  output logic [31:0] fetch_cnt_o
);

  localparam logic [31:0] BYTES = 32'(MEM_BYTES);

  logic [31:0] pc, pc_d, pc4;
  logic [31:0] cnt, cnt_d;
  logic        fault, fault_d;
  logic        load, flush;
  logic        tgt_ok, seq_ok;

  assign pc4    = pc + 32'd4;
  assign tgt_ok = fetch_unit_pkg::legal_addr(target_i, BYTES);
  assign seq_ok = fetch_unit_pkg::legal_addr(pc4, BYTES);

  // A sequential fault still delivers the current word;
  // only the PC step is refused.
  always_comb begin
    pc_d    = pc;
    cnt_d   = cnt;
    fault_d = fault;
    load    = 1'b0;
    flush   = 1'b0;
    if (fault) begin
      flush = 1'b1;
    end else if (redirect_i) begin
      flush = 1'b1;
      if (tgt_ok) pc_d = target_i;
      else fault_d = 1'b1;
    end else if (!stall_i) begin
      load  = 1'b1;
      cnt_d = cnt + 32'd1;
      if (seq_ok) pc_d = pc4;
      else fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      cnt   <= 32'd0;
      fault <= 1'b0;
    end else begin
      pc    <= pc_d;
      cnt   <= cnt_d;
      fault <= fault_d;
    end
  end

  if_id_reg #(
    .NOP(NOP_WORD)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .flush  (flush),
    .instr_d(ins_i),
    .pc_d   (pc),
    .pc4_d  (pc4),
    .instr  (instr_id_o),
    .pc     (pc_id_o),
    .pc4    (pc4_id_o),
    .valid  (valid_id_o)
  );

  assign dr_o        = pc;
  assign fault_o     = fault;
  assign fetch_cnt_o = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a rule-level model predicts every
// post-edge output; a monitor pops and compares after each edge.
module tb_fetch_unit;

  localparam int MEMB = 1000;
  localparam int WORDS = MEMB / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] target_i = 32'd0;
  logic [31:0] ins_i;
  logic [31:0] dr_o, instr_id_o, pc_id_o, pc4_id_o, fetch_cnt_o;
  logic        valid_id_o, fault_o;

  logic [31:0] mem [WORDS];

  typedef struct {
    logic [31:0] dr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_instr, m_pcid, m_pc4id, m_cnt;
  logic        m_valid, m_fault;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .redirect_i (redirect_i),
    .target_i   (target_i),
    .ins_i      (ins_i),
    .dr_o       (dr_o),
    .instr_id_o (instr_id_o),
    .pc_id_o    (pc_id_o),
    .pc4_id_o   (pc4_id_o),
    .valid_id_o (valid_id_o),
    .fault_o    (fault_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    ins_i = 32'd0;
    if (dr_o < 32'(MEMB)) ins_i = mem[dr_o[9:2]];
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a < 32'(MEMB)) return mem[a / 4];
    return 32'd0;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'(MEMB - 4));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, queue the result.
  task automatic cyc(input bit r, input bit st, input bit rd_v,
                     input logic [31:0] tg);
    exp_t e;
    rst = r;
    stall_i = st;
    redirect_i = rd_v;
    target_i = tg;
    if (r) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pcid = 32'd0;
      m_pc4id = 32'd0; m_valid = 1'b0; m_fault = 1'b0;
      m_cnt = 32'd0;
    end else if (m_fault || rd_v) begin
      m_instr = 32'd0; m_pcid = 32'd0; m_pc4id = 32'd0;
      m_valid = 1'b0;
      if (!m_fault) begin
        if (legal(tg)) m_pc = tg;
        else m_fault = 1'b1;
      end
    end else if (!st) begin
      m_instr = rd(m_pc);
      m_pcid = m_pc;
      m_pc4id = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
      if (legal(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
      else m_fault = 1'b1;
    end
    e.dr = m_pc; e.instr = m_instr; e.pc = m_pcid;
    e.pc4 = m_pc4id; e.cnt = m_cnt; e.valid = m_valid;
    e.fault = m_fault;
    q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dr_o", dr_o, e.dr);
        chk("instr_id_o", instr_id_o, e.instr);
        chk("pc_id_o", pc_id_o, e.pc);
        chk("pc4_id_o", pc4_id_o, e.pc4);
        chk("fetch_cnt_o", fetch_cnt_o, e.cnt);
        chk("valid_id_o", 32'(valid_id_o), 32'(e.valid));
        chk("fault_o", 32'(fault_o), 32'(e.fault));
      end
    end
  end

  initial begin : driver
    logic [31:0] tg;
    int r;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;

    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    rst = 1'b0;
    chk("dr_after_reset", dr_o, 32'd0);
    cyc(0, 0, 0, 0);
    chk("first_instr", instr_id_o, 32'h2008_0005);
    chk("first_pc4", pc4_id_o, 32'd4);
    repeat (3) cyc(0, 0, 0, 0);
    chk("seq_dr", dr_o, 32'd16);
    chk("seq_cnt", fetch_cnt_o, 32'd4);

    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    chk("stall_dr", dr_o, 32'd8);
    cyc(0, 0, 0, 0);
    chk("stall_release_pc", pc_id_o, 32'd8);
    cyc(0, 1, 1, 32'h40);
    chk("redir_dr", dr_o, 32'h40);
    cyc(0, 0, 0, 0);
    chk("redir_pc", pc_id_o, 32'h40);
    cyc(0, 0, 1, 32'h42);
    chk("misalign_fault", 32'(fault_o), 32'd1);
    cyc(0, 0, 1, 32'h10);
    chk("fault_freeze_dr", dr_o, 32'h44);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_clears_fault", 32'(fault_o), 32'd0);

    cyc(0, 0, 1, 32'd992);
    repeat (4) cyc(0, 0, 0, 0);
    chk("eom_fault", 32'(fault_o), 32'd1);
    chk("eom_dr", dr_o, 32'd996);
    chk("eom_cnt", fetch_cnt_o, 32'd2);
    cyc(0, 0, 1, 32'd996);
    cyc(0, 0, 0, 32'd1000);
    cyc(1, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      tg = 32'($urandom_range(0, WORDS - 1)) * 4;
      case ($urandom_range(0, 9))
        0: tg = tg + 32'($urandom_range(1, 3));
        1: tg = 32'(MEMB) + 32'($urandom_range(0, 64)) * 4;
        2: tg = 32'(MEMB - 4 * $urandom_range(1, 4));
        default: ;
      endcase
      if (r < 3) cyc(1, 0, 0, 0);
      else if (r < 15) cyc(0, $urandom_range(0, 1) == 1, 1, tg);
      else if (r < 35) cyc(0, 1, 0, tg);
      else cyc(0, 0, 0, tg);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory byte address. It captures the returned 32-bit instruction into the IF/ID pipeline register for the decoder. It also handles stall, branch/jump redirect, and an address-fault check against the memory's 1000-byte bound.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset.
MEM_BYTES, 1000, instruction memory size in bytes; last legal word address is MEM_BYTES-4 = 996.
NOP_WORD, 32'h0000_0000, instruction inserted into IF/ID on bubble, flush or fault.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
stall_i  in  1  hold PC and IF/ID contents (hazard from decode).
redirect_i  in  1  branch taken or jump; load target_i into PC.
target_i  in  32  redirect byte address.
ins_i  in  32  instruction word from the instruction memory, combinational from dr_o.
dr_o  out  32  byte address to the instruction memory; equals PC.
instr_id_o  out  32  IF/ID instruction.
pc_id_o  out  32  IF/ID PC of that instruction.
pc4_id_o  out  32  IF/ID PC+4 of that instruction.
valid_id_o  out  1  IF/ID holds a real instruction.
fault_o  out  1  sticky fetch-address fault.
fetch_cnt_o  out  32  count of instructions delivered into IF/ID.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values:
  - PC = RESET_PC, so dr_o = RESET_PC.
  - instr_id_o = NOP_WORD; pc_id_o = 0; pc4_id_o = 0.
  - valid_id_o = 0; fault_o = 0; fetch_cnt_o = 0.
- dr_o = PC combinationally. The memory returns ins_i in the same cycle. IF/ID captures it at the next edge, so fetch-to-decode latency is 1 cycle.
- Priority per edge: rst > fault > redirect_i > stall_i > sequential.
- Sequential (no stall, no redirect, no fault):
  - PC <= PC+4.
  - IF/ID <= {ins_i, PC, PC+4}, valid=1.
  - fetch_cnt_o increments by 1.
- Stall (stall_i=1, redirect_i=0):
  - PC and all IF/ID outputs hold.
  - fetch_cnt_o holds.
- Redirect (redirect_i=1, legal target):
  - PC <= target_i.
  - IF/ID <= NOP_WORD, pc/pc4 = 0, valid=0. This squashes the wrong-path word.
  - fetch_cnt_o holds.
  - Redirect overrides a simultaneous stall_i.
- Legal address: addr[1:0]==0 and addr <= MEM_BYTES-4. This is checked on target_i when redirect_i=1, and on PC+4 for the sequential step.
- Illegal next address:
  - fault_o <= 1 (sticky until rst).
  - PC keeps its current value.
  - IF/ID <= NOP bubble, valid=0.
  - Sequential case at PC=996: the word at 996 is still delivered with valid=1 on that edge; the fault is raised on the same edge. Every later edge gives a bubble.
- While fault_o=1:
  - PC is frozen; stall_i and redirect_i are ignored.
  - valid_id_o stays 0; fetch_cnt_o is frozen.
- fetch_cnt_o wraps modulo 2^32.
- PC+4 is a 32-bit add with no carry-out. Overflow cannot occur below the fault bound.
- Reset asserted mid-operation wins over any other input on that edge, including an active fault.

Decomposition:
- Shared package: NOP_WORD, MEM_BYTES, RESET_PC, and a word-align mask constant (2'b00).
- One natural sub-module, if_id_reg. It is the pipeline register with load/hold/flush controls for the instr, pc, pc4 and valid fields.
- The PC register, next-PC mux, legality check and counter stay in fetch_unit.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with the memory holding words W0=0x20080005 at 0 and W1 at 4. Cycle 0 after release shows dr_o=0. After 1 edge: instr_id_o=0x20080005, pc_id_o=0, pc4_id_o=4, valid_id_o=1, fetch_cnt_o=1.
- Sequential run: 4 edges with no stall from PC=0 -> dr_o steps 0,4,8,12,16 and fetch_cnt_o=4.
- Stall: stall_i=1 for 3 cycles at PC=8 -> dr_o stays 8, IF/ID outputs unchanged, counter unchanged. On release, the next edge gives pc_id_o=8.
- Redirect with simultaneous stall: redirect_i=1, stall_i=1, target_i=0x40 -> next cycle dr_o=0x40 and valid_id_o=0. One edge later: pc_id_o=0x40, valid_id_o=1.
- Misaligned target: target_i=0x42 with redirect_i=1 -> fault_o=1, dr_o unchanged, valid_id_o=0. A later redirect to 0x10 is ignored. Then rst clears everything to the reset values.
- End of memory: redirect to 992, then run free -> words at 992 and 996 are delivered with valid=1. fault_o rises on the edge that captures 996, dr_o stays 996, and valid_id_o=0 afterwards.
